// File: rtl/join_match_unit_pkg.sv
// Shared types and packet-field helpers for the JOIN matching unit.
// Input token layout is {MONO, PORT, TAG, DATA}; fired packets are {TAG, DATA_L, DATA_R}.
package join_match_unit_pkg;

  localparam int JMU_DATA_W = 16;
  localparam int JMU_TAG_W  = 6;
  localparam int JMU_DEPTH  = 16;

  typedef enum logic [1:0] {
    CLS_MONO,
    CLS_MATCH,
    CLS_DUP,
    CLS_STORE
  } join_cls_e;

  function automatic int in_pkt_size(input int tag_w, input int data_w);
    return 2 + tag_w + data_w;
  endfunction

  function automatic int out_pkt_size(input int tag_w, input int data_w);
    return tag_w + 2 * data_w;
  endfunction

  function automatic int mono_pos(input int tag_w, input int data_w);
    return 1 + tag_w + data_w;
  endfunction

  function automatic int port_pos(input int tag_w, input int data_w);
    return tag_w + data_w;
  endfunction

endpackage

// File: rtl/join_match_unit_cam.sv
// Waiting-operand CAM: parallel tag search with one-hot hit, lowest-free slot
// encoder, a write port into that slot and a free port for the hitting entry.
module join_cam #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 6,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TAG_W-1:0]  i_lookup_tag,
  output logic              o_hit,
  output logic              o_hit_port,
  output logic [DATA_W-1:0] o_hit_data,
  output logic              o_free_any,
  input  logic              i_wr_en,
  input  logic              i_wr_port,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_free_en
);

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_port;
  logic [TAG_W-1:0]  r_tag  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];

  logic [DEPTH-1:0]  w_hit_vec;
  logic              w_hit_port;
  logic [DATA_W-1:0] w_hit_data;
  logic [IDX_W-1:0]  w_free_idx;
  logic              w_free_any;

  // At most one entry per tag is ever valid, so OR-reducing the hit lanes is exact.
  always_comb begin
    w_hit_vec  = '0;
    w_hit_port = 1'b0;
    w_hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_tag[i] == i_lookup_tag)) begin
        w_hit_vec[i] = 1'b1;
        w_hit_port   = w_hit_port | r_port[i];
        w_hit_data   = w_hit_data | r_data[i];
      end
    end
  end

  always_comb begin
    w_free_idx = '0;
    w_free_any = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_idx = IDX_W'(i);
        w_free_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_port  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else if (i_wr_en && w_free_any) begin
      r_valid[w_free_idx] <= 1'b1;
      r_port[w_free_idx]  <= i_wr_port;
      r_tag[w_free_idx]   <= i_lookup_tag;
      r_data[w_free_idx]  <= i_wr_data;
    end else if (i_free_en) begin
      r_valid <= r_valid & ~w_hit_vec;
    end
  end

  assign o_hit      = |w_hit_vec;
  assign o_hit_port = w_hit_port;
  assign o_hit_data = w_hit_data;
  assign o_free_any = w_free_any;

endmodule

// File: rtl/join_match_unit.sv
// Two-operand JOIN unit: arbitrates internal/external tokens, matches pairs by
// tag through join_cam and holds fired packets in a registered output slot.
module join_match_unit
  import join_match_unit_pkg::*;
#(
  parameter int DATA_W = JMU_DATA_W,
  parameter int TAG_W  = JMU_TAG_W,
  parameter int DEPTH  = JMU_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_send_in_ex,
  output logic                       o_ack_out_ex,
  input  logic [TAG_W+DATA_W+1:0]    i_packet_in_external,
  input  logic                       i_send_in_in,
  output logic                       o_ack_out_in,
  input  logic [TAG_W+DATA_W+1:0]    i_packet_in_internal,
  output logic                       o_send_out,
  input  logic                       i_ack_in,
  output logic [TAG_W+2*DATA_W-1:0]  o_packet_out,
  output logic [$clog2(DEPTH):0]     o_occupancy,
  output logic                       o_err_dup
);

  localparam int IN_W     = in_pkt_size(TAG_W, DATA_W);
  localparam int OUT_W    = out_pkt_size(TAG_W, DATA_W);
  localparam int MONO_POS = mono_pos(TAG_W, DATA_W);
  localparam int PORT_POS = port_pos(TAG_W, DATA_W);
  localparam int OCC_W    = $clog2(DEPTH) + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [IN_W-1:0]   w_sel_pkt;
  logic              w_sel_valid;
  logic              w_mono;
  logic              w_port;
  logic [TAG_W-1:0]  w_tag;
  logic [DATA_W-1:0] w_data;
  logic              w_hit;
  logic              w_hit_port;
  logic [DATA_W-1:0] w_hit_data;
  logic              w_free_any;
  join_cls_e         w_cls;
  logic              w_out_free;
  logic              w_can_accept;
  logic              w_take;
  logic              w_fire;
  logic [OUT_W-1:0]  w_fire_pkt;

  logic              r_send_out;
  logic [OUT_W-1:0]  r_packet_out;
  logic [OCC_W-1:0]  r_occ;
  logic              r_err_dup;

  // Internal tokens always win so loop-back traffic can never be starved by the ring.
  assign w_sel_valid = i_send_in_in | i_send_in_ex;
  assign w_sel_pkt   = i_send_in_in ? i_packet_in_internal : i_packet_in_external;
  assign w_mono      = w_sel_pkt[MONO_POS];
  assign w_port      = w_sel_pkt[PORT_POS];
  assign w_tag       = w_sel_pkt[DATA_W +: TAG_W];
  assign w_data      = w_sel_pkt[DATA_W-1:0];

  join_cam #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .DEPTH  (DEPTH)
  ) u_cam (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_lookup_tag (w_tag),
    .o_hit        (w_hit),
    .o_hit_port   (w_hit_port),
    .o_hit_data   (w_hit_data),
    .o_free_any   (w_free_any),
    .i_wr_en      (w_take && (w_cls == CLS_STORE)),
    .i_wr_port    (w_port),
    .i_wr_data    (w_data),
    .i_free_en    (w_take && (w_cls == CLS_MATCH))
  );

  always_comb begin
    w_cls = CLS_STORE;
    if (w_mono) begin
      w_cls = CLS_MONO;
    end else if (w_hit) begin
      w_cls = (w_port != w_hit_port) ? CLS_MATCH : CLS_DUP;
    end
  end

  // A fire may reuse the output slot on the very edge it drains.
  always_comb begin
    w_out_free   = !r_send_out || i_ack_in;
    w_can_accept = 1'b1;
    if ((w_cls == CLS_MONO) || (w_cls == CLS_MATCH)) begin
      w_can_accept = w_out_free;
    end else if (w_cls == CLS_STORE) begin
      w_can_accept = (r_occ < OCC_FULL) && w_free_any;
    end
  end

  assign w_take = rst_n && w_sel_valid && w_can_accept;
  assign w_fire = w_take && ((w_cls == CLS_MONO) || (w_cls == CLS_MATCH));

  always_comb begin
    w_fire_pkt = {w_tag, w_data, {DATA_W{1'b0}}};
    if (w_cls == CLS_MATCH) begin
      w_fire_pkt = w_hit_port ? {w_tag, w_data, w_hit_data}
                              : {w_tag, w_hit_data, w_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_send_out   <= 1'b0;
      r_packet_out <= '0;
      r_occ        <= '0;
      r_err_dup    <= 1'b0;
    end else begin
      if (w_fire) begin
        r_send_out   <= 1'b1;
        r_packet_out <= w_fire_pkt;
      end else if (i_ack_in) begin
        r_send_out   <= 1'b0;
      end
      if (w_take && (w_cls == CLS_STORE)) begin
        r_occ <= r_occ + OCC_W'(1);
      end else if (w_take && (w_cls == CLS_MATCH)) begin
        r_occ <= r_occ - OCC_W'(1);
      end
      if (w_take && (w_cls == CLS_DUP)) begin
        r_err_dup <= 1'b1;
      end
    end
  end

  assign o_ack_out_in = rst_n && i_send_in_in && w_can_accept;
  assign o_ack_out_ex = rst_n && !i_send_in_in && w_can_accept;
  assign o_send_out   = r_send_out;
  assign o_packet_out = r_packet_out;
  assign o_occupancy  = r_occ;
  assign o_err_dup    = r_err_dup;

endmodule
